// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package    : vend_pkg                                            |
// | Description: Shared types and helpers for the vending controller |
// |              (state encoding, index width, price-table slicing). |
// | Revision   : 1.0  initial release                                |
// +------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } vend_state_t;

  // Price tables are zero-extended to this width before slicing so one
  // helper serves every NUM_ITEMS/MONEY_W combination.
  localparam int c_PRICE_VEC_W = 1024;
  localparam int c_VAL_MAX_W   = 32;

  // Product index width; a single product still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns item idx of a packed price table, w bits per item, item 0 in the low slice.
  function automatic logic [c_VAL_MAX_W-1:0] price_slice(
    input logic [c_PRICE_VEC_W-1:0] prices,
    input int                       idx,
    input int                       w
  );
    logic [c_PRICE_VEC_W-1:0] v_sh;
    logic [c_VAL_MAX_W-1:0]   v_mask;
    v_sh   = prices >> (idx * w);
    v_mask = (w >= c_VAL_MAX_W) ? '1 : ((c_VAL_MAX_W'(1) << w) - c_VAL_MAX_W'(1));
    return v_sh[c_VAL_MAX_W-1:0] & v_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_ctrl_multi_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface  : vend_ctrl_multi_if                                  |
// | Description: Coin/select inputs and LED/display outputs of the   |
// |              vending controller. master = front-end side,        |
// |              slave = controller side.                            |
// | Revision   : 1.0  initial release                                |
// +------------------------------------------------------------------+
interface vend_ctrl_multi_if
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int MONEY_W   = 8
);
  localparam int IDX_W = idx_width(NUM_ITEMS);

  logic                 start;
  logic                 cancel;
  logic                 coin_valid;
  logic [MONEY_W-1:0]   coin_val;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;

  logic [MONEY_W-1:0]   credit;
  logic [NUM_ITEMS-1:0] afford;
  logic                 coin_rej;
  logic                 vend_led;
  logic [IDX_W-1:0]     vend_idx;
  logic                 change_led;
  logic [MONEY_W-1:0]   change_amt;
  logic                 busy_led;

  modport master (
    output start, cancel, coin_valid, coin_val, sel_valid, sel_idx,
    input  credit, afford, coin_rej, vend_led, vend_idx, change_led, change_amt, busy_led
  );

  modport slave (
    input  start, cancel, coin_valid, coin_val, sel_valid, sel_idx,
    output credit, afford, coin_rej, vend_led, vend_idx, change_led, change_amt, busy_led
  );

endinterface
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : vend_timer                                          |
// | Description: Up-counter with synchronous clear and a terminal-   |
// |              count flag; the count saturates at term so done     |
// |              stays up until the next clear.                      |
// | Revision   : 1.0  initial release                                |
// +------------------------------------------------------------------+
module vend_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] r_cnt;

  // Count cycles since the last clear, stopping at the terminal value
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt != term) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign done = (r_cnt == term);

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : vend_ctrl_multi                                     |
// | Description: Parametrised vending controller. Owns the credit    |
// |              register, prices NUM_ITEMS products, gives exact    |
// |              change, refunds on cancel or idle timeout.          |
// | Revision   : 1.0  initial release                                |
// +------------------------------------------------------------------+
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int MONEY_W   = 8,
  // Item i lives at PRICES[i*MONEY_W +: MONEY_W]; the default lists the
  // low slice last, so item 0 = 25, item 1 = 15, item 2 = 10, item 3 = 5.
  parameter logic [NUM_ITEMS*MONEY_W-1:0] PRICES = {8'd5, 8'd10, 8'd15, 8'd25},
  parameter int MAX_CREDIT = 99,
  parameter int HOLD_CYC   = 500,
  parameter int IDLE_CYC   = 5000
) (
  input  logic              clk,
  input  logic              rst,
  vend_ctrl_multi_if.slave  bus
);

  localparam int c_IDX_W = idx_width(NUM_ITEMS);
  localparam int c_TMAX  = (HOLD_CYC > IDLE_CYC) ? HOLD_CYC : IDLE_CYC;
  localparam int c_TW    = $clog2(c_TMAX + 1);

  localparam logic [c_TW-1:0]    c_IDLE_TERM = c_TW'(IDLE_CYC - 1);
  localparam logic [c_TW-1:0]    c_HOLD_TERM = c_TW'(HOLD_CYC - 1);
  localparam logic [MONEY_W:0]   c_MAX_CRED  = (MONEY_W+1)'(MAX_CREDIT);
  localparam logic [c_PRICE_VEC_W-1:0] c_PRICES_EXT =
    {{(c_PRICE_VEC_W - NUM_ITEMS*MONEY_W){1'b0}}, PRICES};

  vend_state_t          r_state,    w_state_nxt;
  logic [MONEY_W-1:0]   r_credit,   w_credit_nxt;
  logic [MONEY_W-1:0]   r_change,   w_change_nxt;
  logic [c_IDX_W-1:0]   r_vidx,     w_vidx_nxt;
  logic                 r_rej,      w_rej_nxt;
  logic                 r_chg_led,  w_chg_led_nxt;

  logic [MONEY_W-1:0]   w_price [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] w_afford;
  logic                 w_idx_ok;
  logic [MONEY_W-1:0]   w_sel_price;
  logic                 w_sel_ok;
  logic [MONEY_W:0]     w_sum;
  logic                 w_fits;
  logic                 w_activity;
  logic                 w_tmr_clr;
  logic                 w_tmr_done;
  logic [c_TW-1:0]      w_term;

  // Per-item price decode and affordability, compared against registered credit
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
    assign w_price[gi]  = MONEY_W'(price_slice(c_PRICES_EXT, gi, MONEY_W));
    assign w_afford[gi] = (r_state == ST_COLLECT) && (r_credit >= w_price[gi]);
  end

  assign w_idx_ok    = (32'(bus.sel_idx) < NUM_ITEMS);
  assign w_sel_price = w_idx_ok ? w_price[bus.sel_idx] : '0;
  // Selection is judged on the credit held before any coin of the same cycle.
  assign w_sel_ok    = bus.sel_valid && w_idx_ok && (r_credit >= w_sel_price);
  // One extra bit keeps the overflow test honest when credit+coin exceeds MONEY_W.
  assign w_sum       = {1'b0, r_credit} + {1'b0, bus.coin_val};
  assign w_fits      = (w_sum <= c_MAX_CRED);
  assign w_activity  = bus.coin_valid || bus.sel_valid;

  // The single timer measures idle time in COLLECT and hold time in VEND/REFUND.
  assign w_term = (r_state == ST_COLLECT) ? c_IDLE_TERM : c_HOLD_TERM;

  vend_timer #(
    .W (c_TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_tmr_clr),
    .term (w_term),
    .done (w_tmr_done)
  );

  // Next-state and next-datapath decode, priority select > cancel/timeout > coin
  always_comb begin
    w_state_nxt   = r_state;
    w_credit_nxt  = r_credit;
    w_change_nxt  = r_change;
    w_vidx_nxt    = r_vidx;
    w_chg_led_nxt = r_chg_led;
    w_rej_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_rej_nxt = bus.coin_valid;
        if (bus.start) begin
          w_state_nxt  = ST_COLLECT;
          w_credit_nxt = '0;
        end
      end

      ST_COLLECT: begin
        if (w_sel_ok) begin
          w_state_nxt   = ST_VEND;
          w_change_nxt  = r_credit - w_sel_price;
          w_chg_led_nxt = (r_credit != w_sel_price);
          w_vidx_nxt    = bus.sel_idx;
          w_credit_nxt  = '0;
          w_rej_nxt     = bus.coin_valid;
        end else if (bus.cancel || (w_tmr_done && !w_activity)) begin
          w_state_nxt   = ST_REFUND;
          w_change_nxt  = r_credit;
          w_chg_led_nxt = (r_credit != '0);
          w_credit_nxt  = '0;
          w_rej_nxt     = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (w_fits) begin
            w_credit_nxt = w_sum[MONEY_W-1:0];
          end else begin
            w_rej_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_rej_nxt = bus.coin_valid;
        if (w_tmr_done) begin
          w_state_nxt   = ST_IDLE;
          w_change_nxt  = '0;
          w_vidx_nxt    = '0;
          w_chg_led_nxt = 1'b0;
        end
      end
    endcase

    w_tmr_clr = (r_state == ST_IDLE) || (w_state_nxt != r_state) ||
                ((r_state == ST_COLLECT) && w_activity);
  end

  // State and output registers; reset discards any session in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_credit  <= '0;
      r_change  <= '0;
      r_vidx    <= '0;
      r_rej     <= 1'b0;
      r_chg_led <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_credit  <= w_credit_nxt;
      r_change  <= w_change_nxt;
      r_vidx    <= w_vidx_nxt;
      r_rej     <= w_rej_nxt;
      r_chg_led <= w_chg_led_nxt;
    end
  end

  assign bus.credit     = r_credit;
  assign bus.afford     = w_afford;
  assign bus.coin_rej   = r_rej;
  assign bus.vend_led   = (r_state == ST_VEND);
  assign bus.vend_idx   = r_vidx;
  assign bus.change_led = r_chg_led;
  assign bus.change_amt = r_change;
  assign bus.busy_led   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
